// File: rtl/led_sweep_decoder_if.sv
// -----------------------------------------------------------------------------
// led_sweep_decoder_if
// Bundles the LED bus sampled by the decoder with the telemetry the decoder
// reports back.
//   led        : thermometer-coded LED vector (driven by the flasher side)
//   level      : lit-LED count of the last accepted sample
//   dir        : 00 idle, 01 rising, 10 falling
//   turn       : one-cycle pulse on a direction reversal
//   peak       : level at the last rising->falling reversal
//   trough     : level at the last falling->rising reversal
//   shape_err  : one-cycle pulse, sample was not a thermometer code
//   step_err   : one-cycle pulse, level jumped by more than one
//   err_cnt    : saturating error-cycle counter
//   sweep_cnt  : wrapping count of falling steps landing on level 0
// Modports: master = LED source / telemetry consumer, slave = decoder.
// -----------------------------------------------------------------------------
interface led_sweep_decoder_if #(
    parameter int WIDTH = 16,
    parameter int LW    = 5
);
    logic [WIDTH-1:0] led;
    logic [LW-1:0]    level;
    logic [1:0]       dir;
    logic             turn;
    logic [LW-1:0]    peak;
    logic [LW-1:0]    trough;
    logic             shape_err;
    logic             step_err;
    logic [7:0]       err_cnt;
    logic [7:0]       sweep_cnt;

    modport master (
        output led,
        input  level, dir, turn, peak, trough, shape_err, step_err, err_cnt, sweep_cnt
    );

    modport slave (
        input  led,
        output level, dir, turn, peak, trough, shape_err, step_err, err_cnt, sweep_cnt
    );
endinterface

// File: rtl/led_sweep_decoder.sv
// -----------------------------------------------------------------------------
// led_sweep_decoder
// Receive-side decoder for the bound-flasher LED bus. Samples the thermometer
// LED vector every clock, recovers lamp level and sweep direction, reports
// turn points, counts completed sweeps and flags malformed or jumping samples.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : led_sweep_decoder_if.slave (led in, all telemetry out, registered)
// -----------------------------------------------------------------------------
module led_sweep_decoder #(
    parameter int WIDTH = 16,
    parameter int LW    = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    led_sweep_decoder_if.slave     bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RISING  = 2'b01,
        ST_FALLING = 2'b10
    } state_t;

    localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0] LVL_ONE  = {{(LW-1){1'b0}}, 1'b1};

    // Number of lit LEDs in the sample.
    function automatic logic [LW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [LW-1:0] c;
        c = LVL_ZERO;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + {{(LW-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // A thermometer code is 2^k-1: adding one clears every set bit
    // (all-ones wraps to zero, which is also legal).
    function automatic logic is_thermo(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] v_inc;
        v_inc = v + {{(WIDTH-1){1'b0}}, 1'b1};
        return ((v & v_inc) == {WIDTH{1'b0}});
    endfunction

    state_t        state_r, state_nxt_s;
    logic [LW-1:0] level_r, level_nxt_s;
    logic [LW-1:0] peak_r, peak_nxt_s;
    logic [LW-1:0] trough_r, trough_nxt_s;
    logic [7:0]    err_cnt_r, err_cnt_nxt_s;
    logic [7:0]    sweep_cnt_r, sweep_cnt_nxt_s;
    logic          prev_valid_r, prev_valid_nxt_s;
    logic          turn_r, turn_nxt_s;
    logic          shape_err_r, shape_err_nxt_s;
    logic          step_err_r, step_err_nxt_s;
    logic          err_inc_s;
    logic [LW-1:0] k_s;
    logic          thermo_s;
    logic          up_s;
    logic          dn_s;

    // Sample classification: lit count, shape legality, single-step moves.
    always_comb begin
        k_s      = popcount(bus.led);
        thermo_s = is_thermo(bus.led);
        up_s     = (k_s == (level_r + LVL_ONE));
        dn_s     = ((k_s + LVL_ONE) == level_r);
    end

    // Next-state and next-output decode for the sweep tracker.
    always_comb begin
        state_nxt_s      = state_r;
        level_nxt_s      = level_r;
        peak_nxt_s       = peak_r;
        trough_nxt_s     = trough_r;
        sweep_cnt_nxt_s  = sweep_cnt_r;
        prev_valid_nxt_s = prev_valid_r;
        turn_nxt_s       = 1'b0;
        shape_err_nxt_s  = 1'b0;
        step_err_nxt_s   = 1'b0;
        err_inc_s        = 1'b0;

        if (!thermo_s) begin
            shape_err_nxt_s = 1'b1;
            err_inc_s       = 1'b1;
        end else if (!prev_valid_r) begin
            level_nxt_s      = k_s;
            prev_valid_nxt_s = 1'b1;
        end else if (k_s == level_r) begin
            level_nxt_s = level_r;
        end else if (up_s) begin
            level_nxt_s = k_s;
            case (state_r)
                ST_FALLING: begin
                    turn_nxt_s   = 1'b1;
                    trough_nxt_s = level_r;
                    state_nxt_s  = ST_RISING;
                end
                ST_IDLE:    state_nxt_s = ST_RISING;
                ST_RISING:  state_nxt_s = ST_RISING;
                default:    state_nxt_s = ST_IDLE;
            endcase
        end else if (dn_s) begin
            level_nxt_s = k_s;
            case (state_r)
                ST_RISING: begin
                    turn_nxt_s  = 1'b1;
                    peak_nxt_s  = level_r;
                    state_nxt_s = ST_FALLING;
                end
                ST_IDLE:    state_nxt_s = ST_FALLING;
                ST_FALLING: state_nxt_s = ST_FALLING;
                default:    state_nxt_s = ST_IDLE;
            endcase
            if (k_s == LVL_ZERO) begin
                sweep_cnt_nxt_s = sweep_cnt_r + 8'd1;
            end else begin
                sweep_cnt_nxt_s = sweep_cnt_r;
            end
        end else begin
            // Jump of two or more: resync level, keep direction and history.
            level_nxt_s    = k_s;
            step_err_nxt_s = 1'b1;
            err_inc_s      = 1'b1;
        end

        if (err_inc_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_nxt_s = err_cnt_r + 8'd1;
        end else begin
            err_cnt_nxt_s = err_cnt_r;
        end
    end

    // State and output registers; reset discards the sample at that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            level_r      <= LVL_ZERO;
            peak_r       <= LVL_ZERO;
            trough_r     <= LVL_ZERO;
            err_cnt_r    <= 8'd0;
            sweep_cnt_r  <= 8'd0;
            prev_valid_r <= 1'b0;
            turn_r       <= 1'b0;
            shape_err_r  <= 1'b0;
            step_err_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            level_r      <= level_nxt_s;
            peak_r       <= peak_nxt_s;
            trough_r     <= trough_nxt_s;
            err_cnt_r    <= err_cnt_nxt_s;
            sweep_cnt_r  <= sweep_cnt_nxt_s;
            prev_valid_r <= prev_valid_nxt_s;
            turn_r       <= turn_nxt_s;
            shape_err_r  <= shape_err_nxt_s;
            step_err_r   <= step_err_nxt_s;
        end
    end

    assign bus.level     = level_r;
    assign bus.dir       = state_r;
    assign bus.turn      = turn_r;
    assign bus.peak      = peak_r;
    assign bus.trough    = trough_r;
    assign bus.shape_err = shape_err_r;
    assign bus.step_err  = step_err_r;
    assign bus.err_cnt   = err_cnt_r;
    assign bus.sweep_cnt = sweep_cnt_r;

endmodule
